// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch request, waits WAIT_STATES cycles,
// then presents the word on a response channel that holds under backpressure.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [31:0]   r_pend_addr;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_capture;
  logic          w_pend_err;
  logic          w_load_err;
  logic [AW-1:0] w_pend_idx;
  logic [AW-1:0] w_load_idx;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  assign req_ready  = reset_n && (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_pend_err = addr_bad(r_pend_addr);
  assign w_load_err = addr_bad(load_addr);
  assign w_pend_idx = r_pend_addr[AW+1:2];
  assign w_load_idx = load_addr[AW+1:2];

  // Every accept passes through WAIT; the capture fires on the edge where the
  // counter has already reached zero, giving WAIT_STATES+1 cycles of latency
  // for every legal WAIT_STATES including zero.
  assign w_capture  = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_WAIT;
      S_WAIT:  if (w_capture) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend_addr <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pend_addr <= req_addr;
        r_cnt       <= 4'(WAIT_STATES);
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        // Array read here sees the value before any same-edge load.
        rsp_valid <= 1'b1;
        rsp_addr  <= r_pend_addr;
        rsp_err   <= w_pend_err;
        rsp_data  <= w_pend_err ? '0 : r_mem[w_pend_idx];
      end else if ((r_state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !w_load_err) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed fetches push expectations,
// a negedge monitor pops and compares on every response handshake.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data, rsp_addr;
  logic        rsp_err;
  logic        load_en;
  logic [31:0] load_addr, load_data;
  logic        busy;

  logic        req0_valid, req0_ready;
  logic [31:0] req0_addr;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data, rsp0_addr;
  logic        rsp0_err, busy0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy)
  );

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req0_valid), .req_ready(req0_ready), .req_addr(req0_addr),
    .rsp_valid(rsp0_valid), .rsp_ready(rsp0_ready), .rsp_data(rsp0_data),
    .rsp_addr(rsp0_addr), .rsp_err(rsp0_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_addr", rsp_addr, e.addr);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Issue a fetch; optionally drive a load so that it lands on edge ld_at+1 after accept.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                       input int ld_at, input logic [31:0] ld_a, input logic [31:0] ld_d);
    int lat;
    bit got;
    exp_t e;
    chk("req_ready_before_fetch", {31'd0, req_ready}, 32'd1);
    e.data = ed; e.addr = a; e.err = ee;
    exp_q.push_back(e);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0; req_addr = '0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      if (lat == ld_at) begin
        load_en = 1'b1; load_addr = ld_a; load_data = ld_d;
      end
      tick();
      load_en = 1'b0;
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_latency", 32'(lat), 32'd3);
  endtask

  initial begin
    int seen;
    int lat0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    req0_valid = 1'b0; req0_addr = '0; rsp0_ready = 1'b1;
    repeat (3) tick();
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_addr", rsp_addr, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset_n = 1'b1;
    load(32'h0, 32'h0000_0013);
    load(32'h4, 32'h0010_0093);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    fetch(32'h4, 32'h0010_0093, 1'b0, -1, '0, '0);
    tick();
    chk("idle_after_handshake", {31'd0, busy}, 32'd0);

    fetch(32'h6, 32'h0, 1'b1, -1, '0, '0);
    tick();
    fetch(32'h1000, 32'h0, 1'b1, -1, '0, '0);
    tick();
    load(32'h1000, 32'hDEAD_BEEF);
    fetch(32'h0, 32'h0000_0013, 1'b0, -1, '0, '0);
    tick();

    // Backpressure: response must hold, new request ignored, RESP-time load invisible.
    rsp_ready = 1'b0;
    fetch(32'h4, 32'h0010_0093, 1'b0, -1, '0, '0);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 32'h0;
      if (i == 0) begin
        load_en = 1'b1; load_addr = 32'h4; load_data = 32'h1234_5678;
      end
      tick();
      load_en = 1'b0;
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", rsp_data, 32'h0010_0093);
      chk("stall_rsp_addr", rsp_addr, 32'h4);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("post_stall_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_stall_busy", {31'd0, busy}, 32'd0);
    chk("post_stall_data_kept", rsp_data, 32'h0010_0093);
    fetch(32'h4, 32'h1234_5678, 1'b0, -1, '0, '0);
    tick();

    load(32'h8, 32'hAAAA_AAAA);
    fetch(32'h8, 32'h5555_5555, 1'b0, 0, 32'h8, 32'h5555_5555);
    tick();
    load(32'h8, 32'hAAAA_AAAA);
    fetch(32'h8, 32'hAAAA_AAAA, 1'b0, 2, 32'h8, 32'h5555_5555);
    tick();
    fetch(32'h8, 32'h5555_5555, 1'b0, -1, '0, '0);
    tick();

    // Mid-operation reset: request dropped, nothing pushed to the scoreboard.
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);

    chk("w0_req_ready", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b1; req0_addr = 32'h4;
    tick();
    req0_valid = 1'b0;
    lat0 = 0;
    while (!rsp0_valid && lat0 < 20) begin
      tick();
      lat0++;
    end
    chk("w0_latency", 32'(lat0), 32'd1);
    chk("w0_rsp_data", rsp0_data, 32'h1234_5678);
    chk("w0_rsp_err", {31'd0, rsp0_err}, 32'd0);
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
